pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register for the pipelined CPU: carries NCH payload lanes of W bits each from one stage to the next.
- Generalises the fixed EX/MEM and MEM/WB latches by adding a valid/ready handshake with a one-entry skid buffer, so stalls do not need combinational ready paths.
- Adds synchronous flush (bubble insertion) with control-bit masking, plus a saturating stall-cycle counter for performance debug.
- Instantiated once per stage boundary (IF/ID … MEM/WB) with different NCH.

Parameters:
- NCH, 6: number of payload lanes.
- W, 32: width of each lane in bits.
- CTRL_MASK, 32'h0000_7000: W-bit mask of control bits in lane 0, such as RegWrite and MemtoReg. These bits are forced to 0 on data_o whenever valid_o=0.
- CNT_W, 16: width of the stall counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- valid_i, input, 1: upstream has a payload.
- ready_o, output, 1: stage can accept. Driven from the state register only (registered).
- data_i, input, NCH*W: packed payload. Lane k is data_i[k*W +: W]; lane 0 is the control-signal word.
- flush_i, input, 1: discard all held and incoming payloads this cycle.
- valid_o, output, 1: downstream payload is valid.
- ready_i, input, 1: downstream accepts.
- data_o, output, NCH*W: packed payload out, with lane 0 masked when invalid.
- stall_cnt_o, output, CNT_W: saturating count of cycles with valid_o=1 and ready_i=0.

Behaviour:
- Definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Storage: main register M and skid register S, each NCH*W bits.
- States: EMPTY, FULL (M valid), SKID (M and S valid).
- Output signals: valid_o = (state != EMPTY); ready_o = (state != SKID); data_o = M, except that lane 0 bits in CTRL_MASK read 0 when valid_o=0.
- EMPTY:
  - in_fire → M <= data_i, go to FULL.
- FULL:
  - in_fire & out_fire → M <= data_i, stay in FULL.
  - in_fire & !ready_i → S <= data_i, go to SKID.
  - !in_fire & out_fire → go to EMPTY; M is retained but masked.
  - Otherwise hold.
- SKID:
  - No in_fire is possible, since ready_o=0.
  - out_fire → M <= S, go to FULL.
  - Otherwise hold.
- Latency and ordering: latency is 1 cycle from in_fire to valid_o when the stage was EMPTY or FULL-draining. Full throughput is 1 payload per cycle when ready_i is held at 1. Ordering is strictly FIFO and no payload is ever duplicated.
- Flush:
  - flush_i=1 → next state EMPTY; M and S are cleared to 0.
  - Flush has priority over a simultaneous in_fire: that payload is dropped even though ready_o was 1.
  - Flush has priority over a simultaneous out_fire: the downstream sampled the payload in that cycle, which counts as delivered.
- Stall counter:
  - Increments on each cycle with valid_o & !ready_i, including the flush cycle.
  - Saturates at all-ones; no wrap.
  - Cleared only by rst; flush does not clear it.
- Reset (asynchronous, any time, including mid-transfer):
  - state = EMPTY, M = 0, S = 0, stall_cnt_o = 0.
  - Resulting outputs: valid_o = 0, ready_o = 1, data_o = 0.
  - Handshake resumes on the first rising edge after rst deasserts.
- Width rules: CTRL_MASK is applied to lane 0 only; other lanes are never masked. NCH ≥ 1, W ≥ 1.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (EMPTY/FULL/SKID);
  - the default CTRL_MASK constant;
  - control-bit position constants for lane 0: REGWRITE_BIT = 14, MEMTOREG_LO = 12, MEMTOREG_HI = 13.
- One sub-module: sat_counter (parameter CNT_W; inputs clk, rst, inc; output count). It is reusable for other performance counters.

Test Plan:
- Reset: assert rst mid-SKID with M = 32'hDEAD_BEEF → immediately valid_o = 0, ready_o = 1, data_o = 0, stall_cnt_o = 0.
- Streaming: ready_i = 1, push lane0 = 32'h0000_4000 then 32'h0000_5000 on consecutive cycles → valid_o = 1 one cycle after each push, data_o lane0 in order, no gaps, stall_cnt_o stays 0.
- Backpressure and skid:
  - Stage FULL with A; ready_i = 0 and push B → state SKID, ready_o = 0 next cycle.
  - Hold ready_i = 0 for 3 cycles → stall_cnt_o = 4.
  - Raise ready_i → A then B delivered on consecutive cycles, ready_o returns to 1 after A leaves.
- Flush priority: in SKID, assert flush_i with valid_i = 1 and data 32'h0000_7123 → next cycle valid_o = 0, data_o lane0 = 0, ready_o = 1; payload 32'h0000_7123 never appears on the output.
- Masking: FULL with lane0 = 32'h0000_7ABC, drain with ready_i = 1 and no new input → data_o lane0 reads 32'h0000_0ABC while valid_o = 0; other lanes retain their values.
- Saturation: CNT_W = 4, hold a stall for 20 cycles → stall_cnt_o = 4'hF with no wrap; a flush leaves it at 4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and lane-0 control-bit layout for the CPU inter-stage pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam int REGWRITE_BIT = 14;
  localparam int MEMTOREG_LO  = 12;
  localparam int MEMTOREG_HI  = 13;

  localparam logic [31:0] DEF_CTRL_MASK =
    (32'd1 << REGWRITE_BIT) | (32'd3 << MEMTOREG_LO);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, one step per cycle with inc high; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline register with one-entry skid: 1-cycle latency, full throughput, ready_o decoded from state only.
// Flush empties both entries; lane-0 control bits read as zero while the output is not valid.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int             NCH       = 6,
  parameter int             W         = 32,
  parameter logic [W-1:0]   CTRL_MASK = W'(DEF_CTRL_MASK),
  parameter int             CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [NCH*W-1:0]   data_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [NCH*W-1:0]   data_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int DW = NCH * W;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_m;
  logic [DW-1:0]   r_s;
  logic [DW-1:0]   w_m_nxt;
  logic [DW-1:0]   w_s_nxt;
  logic            w_in_fire;
  logic            w_out_fire;
  logic [W-1:0]    w_lane0_keep;

  assign w_in_fire  = valid_i & ready_o;
  assign w_out_fire = valid_o & ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_m     <= '0;
      r_s     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_m     <= w_m_nxt;
      r_s     <= w_s_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_s_nxt     = r_s;
    if (flush_i) begin
      // Flush beats both a same-cycle accept and a same-cycle delivery.
      w_state_nxt = EMPTY;
      w_m_nxt     = '0;
      w_s_nxt     = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_m_nxt     = data_i;
            w_state_nxt = FULL;
          end
        end
        FULL: begin
          if (w_in_fire && ready_i) begin
            w_m_nxt = data_i;
          end else if (w_in_fire) begin
            w_s_nxt     = data_i;
            w_state_nxt = SKID;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        SKID: begin
          if (w_out_fire) begin
            w_m_nxt     = r_s;
            w_state_nxt = FULL;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    valid_o      = (r_state != EMPTY);
    ready_o      = (r_state != SKID);
    w_lane0_keep = valid_o ? {W{1'b1}} : ~CTRL_MASK;
    data_o          = r_m;
    data_o[W-1:0]   = r_m[W-1:0] & w_lane0_keep;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (valid_o & ~ready_i),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: scoreboard queue filled by stimulus, drained by an output monitor.
module tb_pipe_stage_buf;
  localparam int NCH = 6;
  localparam int W   = 32;
  localparam int DW  = NCH * W;
  localparam int SN  = 2;
  localparam int SDW = SN * W;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i, ready_i, flush_i;
  logic [DW-1:0]   data_i;
  logic            ready_o, valid_o;
  logic [DW-1:0]   data_o;
  logic [15:0]     stall_cnt_o;

  logic            s_valid_i, s_ready_i, s_flush_i;
  logic [SDW-1:0]  s_data_i;
  logic            s_ready_o, s_valid_o;
  logic [SDW-1:0]  s_data_o;
  logic [3:0]      s_stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.NCH(NCH), .W(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .stall_cnt_o(stall_cnt_o)
  );

  pipe_stage_buf #(.NCH(SN), .W(W), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .valid_i(s_valid_i), .ready_o(s_ready_o), .data_i(s_data_i),
    .flush_i(s_flush_i), .valid_o(s_valid_o), .ready_i(s_ready_i), .data_o(s_data_o),
    .stall_cnt_o(s_stall_cnt_o)
  );

  function automatic logic [DW-1:0] mk(input logic [31:0] l0);
    logic [DW-1:0] d;
    for (int k = 0; k < NCH; k++)
      d[k*W +: W] = (k == 0) ? l0 : (l0 ^ ({28'd0, 4'(k)} * 32'h1111_1111));
    return d;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] l0);
    valid_i = 1'b1;
    data_i  = mk(l0);
    exp_q.push_back(mk(l0));
  endtask

  // Every delivered payload must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %h expected none", data_o);
      end else begin
        chk("out_data", data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; data_i = '0;
    s_valid_i = 1'b0; s_ready_i = 1'b0; s_flush_i = 1'b0; s_data_i = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();

    chk("rst_valid", DW'(valid_o), DW'(0));
    chk("rst_ready", DW'(ready_o), DW'(1));
    chk("rst_data", data_o, '0);
    chk("rst_stall", DW'(stall_cnt_o), DW'(0));

    // Streaming
    ready_i = 1'b1;
    push(32'h0000_4000);
    step();
    chk("stream_v1", DW'(valid_o), DW'(1));
    push(32'h0000_5000);
    step();
    chk("stream_v2", DW'(valid_o), DW'(1));
    valid_i = 1'b0;
    step();
    chk("stream_drained", DW'(valid_o), DW'(0));
    chk("stream_stall", DW'(stall_cnt_o), DW'(0));

    // Backpressure into skid
    ready_i = 1'b0;
    push(32'h0000_0A0A);
    step();
    push(32'h0000_0B0B);
    step();
    valid_i = 1'b0;
    chk("skid_ready", DW'(ready_o), DW'(0));
    chk("skid_valid", DW'(valid_o), DW'(1));
    repeat (3) step();
    chk("skid_stall4", DW'(stall_cnt_o), DW'(4));
    ready_i = 1'b1;
    step();
    chk("skid_ready_back", DW'(ready_o), DW'(1));
    chk("skid_b_valid", DW'(valid_o), DW'(1));
    step();
    chk("skid_empty", DW'(valid_o), DW'(0));

    // Flush from SKID, then flush against a live accept
    ready_i = 1'b0;
    push(32'h0000_0C0C);
    step();
    push(32'h0000_0D0D);
    step();
    chk("fl_skid_ready", DW'(ready_o), DW'(0));
    valid_i = 1'b1;
    data_i  = mk(32'h0000_7123);
    flush_i = 1'b1;
    exp_q.delete();
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("fl_valid", DW'(valid_o), DW'(0));
    chk("fl_ready", DW'(ready_o), DW'(1));
    chk("fl_data", data_o, '0);
    chk("fl_stall", DW'(stall_cnt_o), DW'(6));
    valid_i = 1'b1;
    data_i  = mk(32'h0000_7123);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("fl_in_dropped", DW'(valid_o), DW'(0));
    ready_i = 1'b1;
    repeat (3) step();

    // Masking after drain
    ready_i = 1'b0;
    push(32'h0000_7ABC);
    step();
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    chk("mask_valid", DW'(valid_o), DW'(0));
    chk("mask_lane0", DW'(data_o[W-1:0]), DW'(32'h0000_0ABC));
    chk("mask_upper", DW'(data_o[DW-1:W]), DW'(mk(32'h0000_7ABC) >> W));
    chk("mask_stall", DW'(stall_cnt_o), DW'(6));

    // Async reset while in SKID
    ready_i = 1'b0;
    push(32'hDEAD_BEEF);
    step();
    push(32'h0000_1234);
    step();
    valid_i = 1'b0;
    chk("pre_rst_ready", DW'(ready_o), DW'(0));
    chk("pre_rst_lane0", DW'(data_o[W-1:0]), DW'(32'hDEAD_BEEF));
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_valid", DW'(valid_o), DW'(0));
    chk("arst_ready", DW'(ready_o), DW'(1));
    chk("arst_data", data_o, '0);
    chk("arst_stall", DW'(stall_cnt_o), DW'(0));
    @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    step();
    push(32'h0000_1111);
    step();
    valid_i = 1'b0;
    chk("post_rst_valid", DW'(valid_o), DW'(1));
    step();

    // Saturation on the 4-bit counter instance
    chk("sat_rst", DW'(s_stall_cnt_o), DW'(0));
    s_valid_i = 1'b1;
    s_data_i  = {32'h0000_0042, 32'h0000_7001};
    step();
    s_valid_i = 1'b0;
    chk("sat_lane0", DW'(s_data_o[W-1:0]), DW'(32'h0000_7001));
    repeat (14) step();
    chk("sat_14", DW'(s_stall_cnt_o), DW'(4'hE));
    repeat (6) step();
    chk("sat_full", DW'(s_stall_cnt_o), DW'(4'hF));
    s_flush_i = 1'b1;
    step();
    s_flush_i = 1'b0;
    chk("sat_after_flush", DW'(s_stall_cnt_o), DW'(4'hF));
    chk("sat_flush_valid", DW'(s_valid_o), DW'(0));

    chk("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
